// File: rtl/timer_ip.sv
// timer_ip: memory-mapped prescaled timer with compare-match flag.
// Define TIMER_IRQ_EN to implement the IRQEN bit and the irq output.
module timer_ip #(
   parameter int          PRESC_W     = 16,
   parameter logic [31:0] RST_COMPARE = 32'hFFFFFFFF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] waddr,
   input  logic [31:0] wdata,
   input  logic        wen,
   input  logic [3:0]  wstrb,
   output logic        wready,
   input  logic [31:0] raddr,
   input  logic        ren,
   output logic [31:0] rdata,
   output logic        rvalid,
   output logic        irq
);

   localparam logic [2:0] A_CTRL    = 3'd0;
   localparam logic [2:0] A_PRESC   = 3'd1;
   localparam logic [2:0] A_COUNT   = 3'd2;
   localparam logic [2:0] A_COMPARE = 3'd3;
   localparam logic [2:0] A_STATUS  = 3'd4;

   function automatic logic [31:0] merge(
      input logic [31:0] old,
      input logic [31:0] nw,
      input logic [3:0]  s
   );
      logic [31:0] res;
      res = old;
      for (int i = 0; i < 4; i++) begin
         if (s[i]) res[8*i +: 8] = nw[8*i +: 8];
      end
      return res;
   endfunction

   logic               en;
   logic               autoreload;
   logic               irq_en;
   logic [PRESC_W-1:0] presc;
   logic [PRESC_W-1:0] pcnt;
   logic [31:0]        count;
   logic [31:0]        compare;
   logic               match;
   logic               irq_q;

   logic [2:0]  wsel;
   logic [2:0]  rsel;
   logic        wr_ctrl;
   logic        wr_presc;
   logic        wr_count;
   logic        wr_compare;
   logic        wr_status;
   logic        w1c;
   logic        tick;
   logic        hit;
   logic [31:0] presc_wide;
   logic [31:0] rd_mux;

   assign wsel       = waddr[4:2];
   assign rsel       = raddr[4:2];
   assign wr_ctrl    = wen && (wsel == A_CTRL);
   assign wr_presc   = wen && (wsel == A_PRESC);
   assign wr_count   = wen && (wsel == A_COUNT);
   assign wr_compare = wen && (wsel == A_COMPARE);
   assign wr_status  = wen && (wsel == A_STATUS);
   assign w1c        = wr_status && wstrb[0] && wdata[0];

   assign tick       = en && (pcnt == presc);
   assign hit        = (count == compare);
   assign presc_wide = merge(32'(presc), wdata, wstrb);

   // CTRL bits live only in lane 0
   always_ff @(posedge clk) begin
      if (rst) begin
         en         <= 1'b0;
         autoreload <= 1'b0;
      end else if (wr_ctrl && wstrb[0]) begin
         en         <= wdata[0];
         autoreload <= wdata[1];
      end
   end

`ifdef TIMER_IRQ_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         irq_en <= 1'b0;
      end else if (wr_ctrl && wstrb[0]) begin
         irq_en <= wdata[2];
      end
   end
`else
   assign irq_en = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         presc <= '0;
      end else if (wr_presc) begin
         presc <= presc_wide[PRESC_W-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pcnt <= '0;
      end else if (wr_presc || !en || tick) begin
         pcnt <= '0;
      end else begin
         pcnt <= pcnt + 1'b1;
      end
   end

   // a software write to COUNT overrides the tick
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (wr_count) begin
         count <= merge(count, wdata, wstrb);
      end else if (tick) begin
         if (hit && autoreload) count <= '0;
         else                   count <= count + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         compare <= RST_COMPARE;
      end else if (wr_compare) begin
         compare <= merge(compare, wdata, wstrb);
      end
   end

   // set beats clear when both land on one edge
   always_ff @(posedge clk) begin
      if (rst) begin
         match <= 1'b0;
      end else if (tick && hit) begin
         match <= 1'b1;
      end else if (w1c) begin
         match <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         irq_q <= 1'b0;
      end else begin
         irq_q <= match & irq_en;
      end
   end

   assign irq = irq_q;

   always_comb begin
      rd_mux = '0;
      unique case (1'b1)
         (rsel == A_CTRL):    rd_mux = {29'd0, irq_en, autoreload, en};
         (rsel == A_PRESC):   rd_mux = 32'(presc);
         (rsel == A_COUNT):   rd_mux = count;
         (rsel == A_COMPARE): rd_mux = compare;
         (rsel == A_STATUS):  rd_mux = {30'd0, en, match};
         default:             rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rdata  <= '0;
         rvalid <= 1'b0;
         wready <= 1'b0;
      end else begin
         rvalid <= ren;
         wready <= wen;
         if (ren) rdata <= rd_mux;
      end
   end

   logic unused_bits;
   assign unused_bits = ^{waddr[31:5], waddr[1:0],
                          raddr[31:5], raddr[1:0], presc_wide};

endmodule

// File: doc/timer_ip.md
# timer_ip

Memory-mapped 32-bit timer/compare peripheral on the processor's data bus, alongside the UART. It consumes the core's load/store accesses, uses the same waddr/wdata/wen/wstrb/raddr/ren/rdata handshake as the UART, and is selected by the device-select decode. It provides:
- a prescaled free-running or auto-reload counter;
- a sticky compare-match flag;
- an optional level interrupt.

## Interface
Parameters:
- PRESC_W, 16, width of the prescaler register and counter
- RST_COMPARE, 32'hFFFFFFFF, reset value of the COMPARE register

Ports:
- clk  in  1  system clock (clksys domain)
- rst  in  1  synchronous, active-high reset
- waddr  in  32  write byte address; only bits [4:2] are decoded
- wdata  in  32  write data, lane-aligned
- wen  in  1  write strobe, one cycle per access
- wstrb  in  4  byte-lane enables
- wready  out  1  write accepted pulse
- raddr  in  32  read byte address; only bits [4:2] are decoded
- ren  in  1  read strobe
- rdata  out  32  read data
- rvalid  out  1  read data valid pulse
- irq  out  1  level interrupt request

## Operation
Register map (offset in waddr/raddr):
- 0x00 CTRL, RW: bit0 EN, bit1 AUTORELOAD, bit2 IRQEN; other bits read 0.
- 0x04 PRESC, RW, PRESC_W bits. A tick occurs every PRESC+1 clocks.
- 0x08 COUNT, RW, 32 bits.
- 0x0C COMPARE, RW, 32 bits.
- 0x10 STATUS: bit0 MATCH, sticky, write-1-to-clear; bit1 RUNNING, read-only copy of EN.
- Offsets 0x14–0x1C: reads return 0, writes are ignored. Bits [31:5] are ignored; selection is external.

Prescaler:
- Internal counter pcnt. When EN=1: if pcnt==PRESC then pcnt<=0 and tick=1, else pcnt<=pcnt+1.
- When EN=0: pcnt<=0 and no tick is generated.
- Any write to PRESC clears pcnt.

Counter, evaluated on each tick:
- Match = (COUNT==COMPARE). On match, MATCH<=1.
- If match and AUTORELOAD=1: COUNT<=0.
- Otherwise: COUNT<=COUNT+1, modulo 2^32, so 0xFFFFFFFF wraps to 0 with no flag.

Writes:
- Byte-lane granular per wstrb. Lanes with wstrb bit 0 are unchanged.
- A write to STATUS clears MATCH when any enabled lane carries a 1 in bit0 of lane 0, i.e. wstrb[0]=1 and wdata[0]=1.

Collisions:
- Software write to COUNT in the same cycle as a tick: the write wins and the increment is dropped.
- MATCH set and W1C clear in the same cycle: set wins.

irq:
- irq = MATCH & IRQEN, registered.

## Timing
Reset values (rst high at a clk edge):
- CTRL=0, PRESC=0, COUNT=0, COMPARE=RST_COMPARE, MATCH=0, pcnt=0.
- Outputs: rdata=0, rvalid=0, wready=0, irq=0.
- Reset taken mid-count discards all state, and any access in flight produces no rvalid/wready.

Write handshake:
- wen sampled at edge N updates the register at edge N.
- wready is high for the one cycle after N. The core needs no wait states.

Read handshake:
- ren sampled at edge N gives rdata valid with rvalid high for the cycle after N.
- rdata holds its value until the next read. rvalid is a single-cycle pulse.
- Read and write in the same cycle are both serviced. A read of the register being written returns the old value.

Latencies:
- Tick to COUNT update: same edge.
- COUNT==COMPARE at a tick to MATCH=1: that edge.
- MATCH to irq: one further cycle.

Back-to-back:
- wen/ren may be asserted every cycle with no bubbles.
- With PRESC=0, a tick occurs every cycle while EN=1.

## Configuration
- TIMER_IRQ_EN defined: the IRQEN bit is implemented and irq behaves as above.
- TIMER_IRQ_EN undefined:
  - the IRQEN bit is not stored and reads 0;
  - the irq port remains and is tied to 0;
  - MATCH and STATUS behaviour are unchanged, so software polls.

## Test plan
- Reset, then read all five offsets: CTRL=0, PRESC=0, COUNT=0, COMPARE=0xFFFFFFFF, STATUS=0; rvalid is one cycle after each ren; irq=0.
- PRESC=3, COMPARE=5, CTRL=0x7 (EN, AUTORELOAD, IRQEN):
  - COUNT increments every 4 clocks;
  - at the tick where COUNT==5, MATCH=1 and COUNT=0;
  - irq rises one cycle later;
  - writing STATUS=0x1 clears MATCH, and irq falls the next cycle.
- CTRL=0x1, COUNT=0xFFFFFFFE, PRESC=0, COMPARE=0x10: two cycles later COUNT=0x00000000 (wrap) and MATCH stays 0.
- Write COUNT=0x100 on the exact cycle of a tick: the read returns 0x100, not 0x101. Arrange a W1C STATUS write on the cycle a match sets MATCH: MATCH reads 1.
- Byte write wstrb=4'b0100, wdata=0x00AB0000 to COMPARE=0x11223344: COMPARE reads 0x11AB3344.
- Build without TIMER_IRQ_EN and repeat scenario 2: MATCH sets, irq stays 0, and CTRL reads 0x3.
